// File: rtl/rv_trace_checker.sv
// rv_trace_checker: lockstep retirement checker. Buffers the core's commit
// stream in a small FIFO, pulls golden-trace records over valid/ready, and
// compares them field by field. The first divergence freezes the checker and
// is reported together with the index of the offending record.
module rv_trace_checker #(
    parameter int IADDR_SPACE_BITS = 32,
    parameter int FIFO_DEPTH       = 4,
    parameter int CNT_BITS         = 16
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_enable,
    input  logic                        i_commit_valid,
    input  logic [IADDR_SPACE_BITS-1:0] i_commit_pc,
    input  logic [31:0]                 i_commit_instr,
    input  logic                        i_commit_reg_write,
    input  logic [4:0]                  i_commit_rd,
    input  logic [31:0]                 i_commit_rd_data,
    input  logic                        i_rec_valid,
    output logic                        o_rec_ready,
    input  logic [IADDR_SPACE_BITS-1:0] i_rec_pc,
    input  logic [31:0]                 i_rec_instr,
    input  logic                        i_rec_reg_write,
    input  logic [4:0]                  i_rec_rd,
    input  logic [31:0]                 i_rec_rd_data,
    input  logic                        i_rec_last,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_mismatch,
    output logic [3:0]                  o_mismatch_field,
    output logic [CNT_BITS-1:0]         o_mismatch_index,
    output logic                        o_overflow,
    output logic                        o_overrun,
    output logic [CNT_BITS-1:0]         o_checked
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_MISMATCH = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    // Saturating increment used for the matched-record counter.
    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t                state_q, state_d;
    logic                  enable_q;
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0]   idx_q, idx_d;
    logic [CNT_BITS-1:0]   checked_q, checked_d;
    logic                  mismatch_q, mismatch_d;
    logic [3:0]            field_q, field_d;
    logic [CNT_BITS-1:0]   mm_index_q, mm_index_d;
    logic                  done_q, done_d;
    logic                  overflow_q, overflow_d;
    logic                  overrun_q, overrun_d;

    // Compare stage: result of a transfer is applied one edge later.
    logic                  cmp_vld_q, cmp_vld_d;
    logic [3:0]            cmp_field_q;
    logic                  cmp_last_q;

    // Commit buffer storage (data only, never reset).
    logic [IADDR_SPACE_BITS-1:0] fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]                 fifo_instr_q[FIFO_DEPTH];
    logic                        fifo_rw_q   [FIFO_DEPTH];
    logic [4:0]                  fifo_rd_q   [FIFO_DEPTH];
    logic [31:0]                 fifo_data_q [FIFO_DEPTH];

    logic       start;
    logic       fifo_empty;
    logic       fifo_full;
    logic       push;
    logic       drop;
    logic       wr_en;
    logic       rec_ready;
    logic       xfer;
    logic [3:0] field_now;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    assign head       = rd_ptr_q[PTR_W-1:0];
    assign tail       = wr_ptr_q[PTR_W-1:0];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) && (tail == head);
    // A new run starts on an enable rising edge from any non-running state.
    assign start      = i_enable && !enable_q && (state_q != S_RUN);
    assign push       = (state_q == S_RUN) && i_commit_valid;
    assign rec_ready  = (state_q == S_RUN) && !fifo_empty;
    assign xfer       = rec_ready && i_rec_valid;
    // A pop in the same cycle frees a slot, so only push-without-pop on full drops.
    assign drop       = push && fifo_full && !xfer;
    assign wr_en      = push && !drop;

    // Field-by-field comparison of the FIFO head against the presented record.
    always_comb begin
        field_now    = 4'b0000;
        field_now[0] = (fifo_pc_q[head] != i_rec_pc) || (fifo_instr_q[head] != i_rec_instr);
        field_now[1] = (fifo_rw_q[head] != i_rec_reg_write);
        if (fifo_rw_q[head] && i_rec_reg_write) begin
            field_now[2] = (fifo_rd_q[head] != i_rec_rd);
            // Writes to x0 are architecturally discarded, so their data is not compared.
            field_now[3] = (fifo_data_q[head] != i_rec_rd_data) && (i_rec_rd != 5'd0);
        end
    end

    // Next-state logic for the run FSM, FIFO pointers, counters and sticky flags.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        idx_d      = idx_q;
        checked_d  = checked_q;
        mismatch_d = mismatch_q;
        field_d    = field_q;
        mm_index_d = mm_index_q;
        done_d     = done_q;
        overflow_d = overflow_q;
        overrun_d  = overrun_q;
        cmp_vld_d  = 1'b0;

        if (start) begin
            state_d    = S_RUN;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            idx_d      = '0;
            checked_d  = '0;
            mismatch_d = 1'b0;
            field_d    = 4'b0000;
            mm_index_d = '0;
            done_d     = 1'b0;
            overflow_d = 1'b0;
            overrun_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
                    if (xfer)  rd_ptr_d = rd_ptr_q + 1'b1;
                    cmp_vld_d = xfer;
                    if (cmp_vld_q) begin
                        if (|cmp_field_q) begin
                            mismatch_d = 1'b1;
                            field_d    = cmp_field_q;
                            mm_index_d = idx_q;
                            state_d    = S_MISMATCH;
                        end else begin
                            checked_d = sat_inc(checked_q);
                            idx_d     = idx_q + 1'b1;
                            if (cmp_last_q) begin
                                done_d  = 1'b1;
                                state_d = S_DONE;
                            end
                        end
                    end
                    // A lost commit makes the rest of the trace unalignable.
                    if (drop) begin
                        overflow_d = 1'b1;
                        if (state_d == S_RUN) begin
                            mismatch_d = 1'b1;
                            field_d    = 4'b0000;
                            mm_index_d = idx_d;
                            state_d    = S_MISMATCH;
                        end
                    end
                    if (!i_enable) state_d = S_IDLE;
                end
                S_DONE: begin
                    if (i_commit_valid) overrun_d = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            enable_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            idx_q      <= '0;
            checked_q  <= '0;
            mismatch_q <= 1'b0;
            field_q    <= 4'b0000;
            mm_index_q <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            overrun_q  <= 1'b0;
            cmp_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            enable_q   <= i_enable;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            idx_q      <= idx_d;
            checked_q  <= checked_d;
            mismatch_q <= mismatch_d;
            field_q    <= field_d;
            mm_index_q <= mm_index_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            overrun_q  <= overrun_d;
            cmp_vld_q  <= cmp_vld_d;
        end
    end

    // Datapath registers: FIFO storage and the compare-stage payload.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            fifo_pc_q[tail]    <= i_commit_pc;
            fifo_instr_q[tail] <= i_commit_instr;
            fifo_rw_q[tail]    <= i_commit_reg_write;
            fifo_rd_q[tail]    <= i_commit_rd;
            fifo_data_q[tail]  <= i_commit_rd_data;
        end
        cmp_field_q <= field_now;
        cmp_last_q  <= i_rec_last;
    end

    assign o_rec_ready      = rec_ready;
    assign o_busy           = (state_q == S_RUN);
    assign o_done           = done_q;
    assign o_mismatch       = mismatch_q;
    assign o_mismatch_field = field_q;
    assign o_mismatch_index = mm_index_q;
    assign o_overflow       = overflow_q;
    assign o_overrun        = overrun_q;
    assign o_checked        = checked_q;

endmodule

// File: tb/tb_rv_trace_checker.sv
// Directed bench for rv_trace_checker: match, divergence, x0 writes,
// overflow, full-FIFO push/pop, overrun, reset and re-arm.
module tb_rv_trace_checker;

    logic        clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_enable = 1'b0;
    logic        i_commit_valid = 1'b0;
    logic [31:0] i_commit_pc = '0;
    logic [31:0] i_commit_instr = '0;
    logic        i_commit_reg_write = 1'b0;
    logic [4:0]  i_commit_rd = '0;
    logic [31:0] i_commit_rd_data = '0;
    logic        i_rec_valid = 1'b0;
    logic        o_rec_ready;
    logic [31:0] i_rec_pc = '0;
    logic [31:0] i_rec_instr = '0;
    logic        i_rec_reg_write = 1'b0;
    logic [4:0]  i_rec_rd = '0;
    logic [31:0] i_rec_rd_data = '0;
    logic        i_rec_last = 1'b0;
    logic        o_busy;
    logic        o_done;
    logic        o_mismatch;
    logic [3:0]  o_mismatch_field;
    logic [15:0] o_mismatch_index;
    logic        o_overflow;
    logic        o_overrun;
    logic [15:0] o_checked;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rv_trace_checker #(
        .IADDR_SPACE_BITS(32),
        .FIFO_DEPTH(4),
        .CNT_BITS(16)
    ) dut (
        .i_clk(clk),
        .i_reset(i_reset),
        .i_enable(i_enable),
        .i_commit_valid(i_commit_valid),
        .i_commit_pc(i_commit_pc),
        .i_commit_instr(i_commit_instr),
        .i_commit_reg_write(i_commit_reg_write),
        .i_commit_rd(i_commit_rd),
        .i_commit_rd_data(i_commit_rd_data),
        .i_rec_valid(i_rec_valid),
        .o_rec_ready(o_rec_ready),
        .i_rec_pc(i_rec_pc),
        .i_rec_instr(i_rec_instr),
        .i_rec_reg_write(i_rec_reg_write),
        .i_rec_rd(i_rec_rd),
        .i_rec_rd_data(i_rec_rd_data),
        .i_rec_last(i_rec_last),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_mismatch(o_mismatch),
        .o_mismatch_field(o_mismatch_field),
        .o_mismatch_index(o_mismatch_index),
        .o_overflow(o_overflow),
        .o_overrun(o_overrun),
        .o_checked(o_checked)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cmt(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rw, input logic [4:0] rd, input logic [31:0] d);
        i_commit_valid     = v;
        i_commit_pc        = pc;
        i_commit_instr     = ins;
        i_commit_reg_write = rw;
        i_commit_rd        = rd;
        i_commit_rd_data   = d;
    endtask

    task automatic rec(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rw, input logic [4:0] rd, input logic [31:0] d,
                       input logic last);
        i_rec_valid     = v;
        i_rec_pc        = pc;
        i_rec_instr     = ins;
        i_rec_reg_write = rw;
        i_rec_rd        = rd;
        i_rec_rd_data   = d;
        i_rec_last      = last;
    endtask

    task automatic rearm();
        i_enable = 1'b0;
        tick();
        i_enable = 1'b1;
        tick();
    endtask

    initial begin
        // Reset state
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_ready", 32'(o_rec_ready), 32'd0);
        check("rst_checked", 32'(o_checked), 32'd0);
        check("rst_mismatch", 32'(o_mismatch), 32'd0);

        // Match: three commits, identical records, last on the third
        i_enable = 1'b1;
        tick();
        check("m_busy", 32'(o_busy), 32'd1);
        cmt(1, 32'h0, 32'h00500093, 1, 5'd1, 32'd5);
        tick();
        check("m_ready", 32'(o_rec_ready), 32'd1);
        cmt(1, 32'h4, 32'h00700113, 1, 5'd2, 32'd7);
        rec(1, 32'h0, 32'h00500093, 1, 5'd1, 32'd5, 0);
        tick();
        cmt(1, 32'h8, 32'h002081B3, 1, 5'd3, 32'd12);
        rec(1, 32'h4, 32'h00700113, 1, 5'd2, 32'd7, 0);
        tick();
        check("m_checked1", 32'(o_checked), 32'd1);
        cmt(0, 0, 0, 0, 0, 0);
        rec(1, 32'h8, 32'h002081B3, 1, 5'd3, 32'd12, 1);
        tick();
        rec(0, 0, 0, 0, 0, 0, 0);
        tick();
        check("m_checked", 32'(o_checked), 32'd3);
        check("m_done", 32'(o_done), 32'd1);
        check("m_mismatch", 32'(o_mismatch), 32'd0);
        check("m_busy_end", 32'(o_busy), 32'd0);
        check("m_ready_end", 32'(o_rec_ready), 32'd0);

        // Overrun: commit after done
        check("ovr_pre", 32'(o_overrun), 32'd0);
        cmt(1, 32'hC, 32'h00000013, 0, 0, 0);
        tick();
        cmt(0, 0, 0, 0, 0, 0);
        check("ovr_set", 32'(o_overrun), 32'd1);

        // Data divergence on record index 1
        rearm();
        check("dd_overrun_clr", 32'(o_overrun), 32'd0);
        check("dd_done_clr", 32'(o_done), 32'd0);
        check("dd_checked_clr", 32'(o_checked), 32'd0);
        cmt(1, 32'h0, 32'h00500093, 1, 5'd1, 32'd5);
        tick();
        cmt(1, 32'h4, 32'h00108093, 1, 5'd1, 32'd6);
        rec(1, 32'h0, 32'h00500093, 1, 5'd1, 32'd5, 0);
        tick();
        cmt(0, 0, 0, 0, 0, 0);
        rec(1, 32'h4, 32'h00108093, 1, 5'd1, 32'd5, 0);
        tick();
        rec(0, 0, 0, 0, 0, 0, 0);
        tick();
        check("dd_mismatch", 32'(o_mismatch), 32'd1);
        check("dd_field", 32'(o_mismatch_field), 32'h8);
        check("dd_index", 32'(o_mismatch_index), 32'd1);
        check("dd_ready", 32'(o_rec_ready), 32'd0);
        check("dd_checked", 32'(o_checked), 32'd1);

        // x0 write: data ignored when expected rd is 0
        rearm();
        cmt(1, 32'h0, 32'h00000013, 1, 5'd0, 32'hDEAD);
        tick();
        cmt(0, 0, 0, 0, 0, 0);
        rec(1, 32'h0, 32'h00000013, 1, 5'd0, 32'h0, 1);
        tick();
        rec(0, 0, 0, 0, 0, 0, 0);
        tick();
        check("x0_mismatch", 32'(o_mismatch), 32'd0);
        check("x0_checked", 32'(o_checked), 32'd1);
        check("x0_done", 32'(o_done), 32'd1);

        // Overflow: five commits into a four-entry buffer with no records
        rearm();
        for (int i = 0; i < 4; i++) begin
            cmt(1, 32'(4 * i), 32'h00000013, 0, 0, 0);
            tick();
        end
        check("of_busy4", 32'(o_busy), 32'd1);
        check("of_flag4", 32'(o_overflow), 32'd0);
        cmt(1, 32'h10, 32'h00000013, 0, 0, 0);
        tick();
        cmt(0, 0, 0, 0, 0, 0);
        check("of_flag5", 32'(o_overflow), 32'd1);
        check("of_mismatch", 32'(o_mismatch), 32'd1);
        check("of_field", 32'(o_mismatch_field), 32'h0);
        check("of_index", 32'(o_mismatch_index), 32'd0);
        check("of_busy5", 32'(o_busy), 32'd0);

        // Four commits fill the buffer exactly, then all records match
        rearm();
        for (int i = 0; i < 4; i++) begin
            cmt(1, 32'(4 * i), 32'h00000013, 0, 0, 0);
            tick();
        end
        cmt(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            rec(1, 32'(4 * i), 32'h00000013, 0, 0, 0, (i == 3));
            tick();
        end
        rec(0, 0, 0, 0, 0, 0, 0);
        tick();
        check("f4_checked", 32'(o_checked), 32'd4);
        check("f4_done", 32'(o_done), 32'd1);
        check("f4_overflow", 32'(o_overflow), 32'd0);

        // Full buffer: push and pop in the same cycle
        rearm();
        for (int i = 0; i < 4; i++) begin
            cmt(1, 32'(4 * i), 32'h00000013, 0, 0, 0);
            tick();
        end
        cmt(1, 32'h10, 32'h00000013, 0, 0, 0);
        rec(1, 32'h0, 32'h00000013, 0, 0, 0, 0);
        tick();
        cmt(0, 0, 0, 0, 0, 0);
        check("pp_overflow", 32'(o_overflow), 32'd0);
        check("pp_busy", 32'(o_busy), 32'd1);
        for (int i = 1; i < 5; i++) begin
            rec(1, 32'(4 * i), 32'h00000013, 0, 0, 0, (i == 4));
            tick();
        end
        rec(0, 0, 0, 0, 0, 0, 0);
        tick();
        check("pp_checked", 32'(o_checked), 32'd5);
        check("pp_done", 32'(o_done), 32'd1);
        check("pp_mismatch", 32'(o_mismatch), 32'd0);

        // Reset mid-run clears everything
        rearm();
        cmt(1, 32'h0, 32'h00500093, 1, 5'd1, 32'd5);
        tick();
        cmt(1, 32'h4, 32'h00700113, 1, 5'd2, 32'd7);
        rec(1, 32'h0, 32'h00500093, 1, 5'd1, 32'd5, 0);
        tick();
        cmt(0, 0, 0, 0, 0, 0);
        rec(0, 0, 0, 0, 0, 0, 0);
        tick();
        check("mr_checked", 32'(o_checked), 32'd1);
        check("mr_ready", 32'(o_rec_ready), 32'd1);
        i_reset = 1'b1;
        tick();
        i_reset  = 1'b0;
        i_enable = 1'b0;
        check("rr_busy", 32'(o_busy), 32'd0);
        check("rr_checked", 32'(o_checked), 32'd0);
        check("rr_ready", 32'(o_rec_ready), 32'd0);
        check("rr_done", 32'(o_done), 32'd0);

        // Commits are ignored while idle
        cmt(1, 32'h40, 32'h00000013, 0, 0, 0);
        tick();
        cmt(0, 0, 0, 0, 0, 0);
        check("idle_busy", 32'(o_busy), 32'd0);
        i_enable = 1'b1;
        tick();
        check("ra_busy", 32'(o_busy), 32'd1);
        check("ra_ready", 32'(o_rec_ready), 32'd0);

        // Fresh run: pc and reg_write divergence on record 0
        cmt(1, 32'h0, 32'h00500093, 1, 5'd1, 32'd5);
        tick();
        cmt(0, 0, 0, 0, 0, 0);
        rec(1, 32'h4, 32'h00500093, 0, 5'd1, 32'd5, 0);
        tick();
        rec(0, 0, 0, 0, 0, 0, 0);
        tick();
        check("fr_mismatch", 32'(o_mismatch), 32'd1);
        check("fr_field", 32'(o_mismatch_field), 32'h3);
        check("fr_index", 32'(o_mismatch_index), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_trace_checker.md
Name: rv_trace_checker

Overview:
- Lockstep retirement checker for simulation and FPGA bring-up.
- Consumes the core's writeback-stage commit stream and reads expected retirement records from a golden-trace source over a valid/ready stream.
- Compares each commit against its record field by field, and reports the first divergence with its record index.
- Sits beside the trace logger on the same commit signals; it reads a trace where the logger writes one.

Parameters:
- IADDR_SPACE_BITS, 32, width of PC fields.
- FIFO_DEPTH, 4, commit buffer entries; power of two, minimum 2.
- CNT_BITS, 16, width of record index and checked counter.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous active-high reset.
- i_enable  in  1  checker enable; rising edge starts a run.
- i_commit_valid  in  1  instruction retired this cycle.
- i_commit_pc  in  IADDR_SPACE_BITS  retired PC.
- i_commit_instr  in  32  retired opcode.
- i_commit_reg_write  in  1  rd written.
- i_commit_rd  in  5  destination register.
- i_commit_rd_data  in  32  value written.
- i_rec_valid  in  1  expected record available.
- o_rec_ready  out  1  checker consumes record.
- i_rec_pc  in  IADDR_SPACE_BITS  expected PC.
- i_rec_instr  in  32  expected opcode.
- i_rec_reg_write  in  1  expected rd write.
- i_rec_rd  in  5  expected rd.
- i_rec_rd_data  in  32  expected value.
- i_rec_last  in  1  final record of trace.
- o_busy  out  1  state is RUN.
- o_done  out  1  last record matched.
- o_mismatch  out  1  sticky divergence flag.
- o_mismatch_field  out  4  sticky mask: {data, rd, reg_write, pc/instr}.
- o_mismatch_index  out  CNT_BITS  index of the failing record.
- o_overflow  out  1  sticky: commit lost because the FIFO was full.
- o_overrun  out  1  sticky: commit arrived in DONE.
- o_checked  out  CNT_BITS  records matched; saturates.

Behaviour:

Reset:
- Reset is synchronous and active-high. All outputs, FIFO pointers and counters go to 0, and the state goes to IDLE, at the next i_clk edge.
- Reset asserted mid-run aborts the run with no flags retained.

States:
- IDLE: o_rec_ready=0 and commits are ignored. On an i_enable rising edge (registered previous value), clear the FIFO, counters and all sticky flags, then go to RUN.
- RUN: a commit with i_commit_valid=1 is pushed into the FIFO.
  - o_rec_ready = FIFO not empty (combinational from registered pointers).
  - A transfer occurs when i_rec_valid & o_rec_ready; it pops the FIFO head and compares it against the record.
- MISMATCH: terminal until reset or an i_enable re-arm (low, then high). o_rec_ready=0.
- DONE: terminal like MISMATCH. o_rec_ready=0. Any commit sets o_overrun.
- i_enable low in RUN: go to IDLE, and sticky flags hold their values.

Compare rules on a transfer:
- Field bit 0: set if pc or instr differs.
- Field bit 1: set if reg_write differs.
- If both sides have reg_write=1:
  - Field bit 2: set if rd differs.
  - Field bit 3: set if rd_data differs and expected rd != 0.
- When both reg_write are 0, rd and data are ignored.

Compare outcome (registered; transfer at edge T, flags visible after edge T+1):
- Any field bit set: o_mismatch=1, o_mismatch_field latched, o_mismatch_index = current index, state to MISMATCH.
- No field bit set: o_checked increments (holds at all-ones), index increments (wraps).
- No mismatch and i_rec_last=1: o_done=1, state to DONE.

Latency and FIFO:
- Minimum latency is commit at edge N, transfer at N+1, flag at N+2.
- Push and pop in the same cycle are legal at any occupancy, including full: occupancy is unchanged.
- A push while full with no pop drops the commit, sets o_overflow, and sends the state to MISMATCH with field 0 and the current index.
- Empty FIFO: no transfer regardless of i_rec_valid.
- Record inputs must be held stable while i_rec_valid=1 and o_rec_ready=0.

Test Plan:
- Match: 3 commits with pc 0x0,0x4,0x8 and instr 0x00500093 (addi r1,r0,5) etc., records identical, last on the third -> o_checked=3, o_done=1, o_mismatch=0.
- Data divergence: record 2 expects rd_data 0x5 while the commit writes 0x6 to r1 -> o_mismatch=1, field=4'b1000, index=1, o_rec_ready=0 afterwards.
- x0 write: expected rd=0 with rd_data 0x0 vs commit rd=0 with rd_data 0xDEAD -> no mismatch, o_checked increments.
- Backpressure and overflow: i_rec_valid=0 with 5 consecutive commits at FIFO_DEPTH=4 -> o_overflow=1 on the 5th, state MISMATCH, field=0. Repeat with 4 commits, then records -> all match.
- Simultaneous push/pop when full: FIFO full, commit and transfer in the same cycle -> no overflow, order preserved.
- Overrun, reset and re-arm:
  - A commit after o_done -> o_overrun=1.
  - Assert i_reset for 1 cycle mid-RUN -> all outputs 0, state IDLE.
  - i_enable 0->1 -> fresh run, index starts at 0.
